fifo_mac_stage: RTL

- Downstream consumer of the activation FIFO in the accelerator datapath.
- On `start`, pops `vec_len` activation words from the FIFO head and fetches matching weights from a synchronous weight memory.
- Multiply-accumulates onto a bias, then applies fixed-point rescale, saturation and optional ReLU.
- Presents one neuron output on a valid/ready handshake.

---
 rtl/fifo_mac_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fifo_mac_stage.sv
// rtl/fifo_mac_stage.sv - FIFO-fed dot-product neuron with rescale, saturation and ReLU
module fifo_mac_stage #(
    parameter int DATA_W  = 16,
    parameter int FRAC    = 8,
    parameter int ACC_W   = 40,
    parameter int LEN_W   = 8,
    parameter int WADDR_W = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [LEN_W-1:0]          vec_len,
    input  logic [WADDR_W-1:0]        weight_base,
    input  logic signed [DATA_W-1:0]  bias,
    input  logic                      relu_en,
    output logic                      busy,
    input  logic                      fifo_empty,
    input  logic signed [DATA_W-1:0]  fifo_data,
    output logic                      fifo_read_update,
    output logic [WADDR_W-1:0]        weight_addr,
    input  logic signed [DATA_W-1:0]  weight_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W-1:0]  out_data
);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH, S_OUTPUT} state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t                     state, state_nx;
    logic [LEN_W-1:0]           len_r;
    logic [LEN_W-1:0]           count;
    logic [WADDR_W-1:0]         base_r;
    logic                       relu_r;
    logic signed [ACC_W-1:0]    acc;
    logic signed [DATA_W-1:0]   act_r;
    logic                       mac_pend;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [DATA_W-1:0]   sat_val;

    assign busy        = (state != S_IDLE);
    assign weight_addr = base_r + WADDR_W'(count);

    // Weight memory returns data one cycle after the address, aligned with act_r.
    assign prod     = act_r * weight_data;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W-FRAC){bias[DATA_W-1]}}, bias, {FRAC{1'b0}}};
    assign shifted  = acc >>> FRAC;

    always_comb begin
        sat_val = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_W-1:0];
        end
        if (relu_r && sat_val[DATA_W-1]) begin
            sat_val = '0;
        end
    end

    always_comb begin
        state_nx         = state;
        fifo_read_update = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (vec_len == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                if (!fifo_empty) begin
                    fifo_read_update = 1'b1;
                    if (count == len_r - LEN_W'(1)) begin
                        state_nx = S_DRAIN;
                    end
                end
            end
            S_DRAIN:  state_nx = S_FINISH;
            S_FINISH: state_nx = S_OUTPUT;
            S_OUTPUT: begin
                if (out_valid && out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            len_r     <= '0;
            count     <= '0;
            base_r    <= '0;
            relu_r    <= 1'b0;
            acc       <= '0;
            act_r     <= '0;
            mac_pend  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state    <= state_nx;
            mac_pend <= fifo_read_update;
            if (mac_pend) begin
                acc <= acc + prod_ext;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_r  <= vec_len;
                        base_r <= weight_base;
                        relu_r <= relu_en;
                        acc    <= bias_ext;
                        count  <= '0;
                    end
                end
                S_RUN: begin
                    if (fifo_read_update) begin
                        act_r <= fifo_data;
                        count <= count + LEN_W'(1);
                    end
                end
                S_FINISH: out_data <= sat_val;
                // Result is registered in FINISH; valid follows one cycle later.
                S_OUTPUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
